// File: rtl/zap_wb_mem_responder.sv
// Wishbone B3 target backed by a word-wide synchronous RAM, with programmable wait states
// before the first beat and CTI incrementing bursts (one beat per cycle after the first).
module zap_wb_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_wen,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [2:0]  i_wb_cti,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err
);
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WS       = 4'(WAIT_STATES);
    localparam logic [2:0]  CTI_INCR = 3'b010;

    // IDLE: no cycle | WAIT: counting wait states | BEAT: ack/err cycle, or burst stalled on stb
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_t;

    state_t      state;
    logic [31:0] adr_q;
    logic        wen_q;
    logic [3:0]  wait_cnt;
    logic [31:0] mem [DEPTH_WORDS];

    logic [32:0] beat_adr;
    logic        beat_wen;
    logic        beat_ok;
    logic [31:0] beat_dat;
    logic        ram_we;
    logic        unused_adr_lsb;

    assign unused_adr_lsb = ^i_wb_adr[1:0];

    function automatic logic in_range(input logic [32:0] a);
        logic [32:0] off;
        off = a - {1'b0, BASE_ADDR};
        return (a >= {1'b0, BASE_ADDR}) && (off < SPAN);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[AW+1:2];
    endfunction

    // Address of the beat that would be presented at this edge; carry out of bit 31 is an error.
    always_comb begin
        beat_adr = {1'b0, adr_q};
        beat_wen = wen_q;
        case (state)
            S_IDLE: begin
                beat_adr = {1'b0, i_wb_adr[31:2], 2'b00};
                beat_wen = i_wb_wen;
            end
            S_BEAT: if (o_wb_ack) beat_adr = {1'b0, adr_q} + 33'd4;
            default: ;
        endcase
        beat_ok  = in_range(beat_adr);
        beat_dat = (beat_ok && !beat_wen) ? mem[word_idx(beat_adr[31:0])] : 32'h0;
    end

    assign ram_we = !i_reset && (state == S_BEAT) && o_wb_ack && i_wb_cyc && i_wb_stb && wen_q;

    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_wb_sel[i]) mem[word_idx(adr_q)][8*i +: 8] <= i_wb_dat[8*i +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= S_IDLE;
            adr_q    <= 32'h0;
            wen_q    <= 1'b0;
            wait_cnt <= 4'h0;
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= 32'h0;
        end else begin
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= 32'h0;
            case (state)
                S_IDLE: begin
                    if (i_wb_cyc && i_wb_stb) begin
                        adr_q    <= beat_adr[31:0];
                        wen_q    <= i_wb_wen;
                        wait_cnt <= WS;
                        if (WS == 4'h0) begin
                            state    <= S_BEAT;
                            o_wb_ack <= beat_ok;
                            o_wb_err <= !beat_ok;
                            o_wb_dat <= beat_dat;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!i_wb_cyc) begin
                        state <= S_IDLE;
                    end else if (wait_cnt <= 4'h1) begin
                        wait_cnt <= 4'h0;
                        state    <= S_BEAT;
                        o_wb_ack <= beat_ok;
                        o_wb_err <= !beat_ok;
                        o_wb_dat <= beat_dat;
                    end else begin
                        wait_cnt <= wait_cnt - 4'h1;
                    end
                end
                S_BEAT: begin
                    if (!i_wb_cyc || o_wb_err) begin
                        state <= S_IDLE;
                    end else if (o_wb_ack) begin
                        // ack without stb was not taken by the manager; it is re-presented later
                        if (i_wb_stb) begin
                            if (i_wb_cti == CTI_INCR) begin
                                adr_q    <= beat_adr[31:0];
                                o_wb_ack <= beat_ok;
                                o_wb_err <= !beat_ok;
                                o_wb_dat <= beat_dat;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end else if (i_wb_stb) begin
                        o_wb_ack <= beat_ok;
                        o_wb_err <= !beat_ok;
                        o_wb_dat <= beat_dat;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && state == S_BEAT && o_wb_ack && i_wb_cyc && i_wb_stb)
            assert (i_wb_adr[31:2] == adr_q[31:2]);
    end
endmodule

// File: tb/tb_zap_wb_mem_responder.sv
// Directed bench for zap_wb_mem_responder: transfers push expected beats into a scoreboard,
// a negedge monitor pops and compares on every ack/err.
module tb_zap_wb_mem_responder;
    localparam int          WS    = 3;
    localparam int          DEPTH = 64;
    localparam logic [31:0] TOP   = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, wen = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic [2:0]  cti = 3'b000;
    logic [31:0] rdat;
    logic        ack, err;

    zap_wb_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(WS)) dut (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_wen(wen),
        .i_wb_sel(sel), .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_cti(cti),
        .o_wb_dat(rdat), .o_wb_ack(ack), .o_wb_err(err)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct { logic err; logic [31:0] dat; int cyc; } exp_t;
    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    logic [31:0] tx_dat [8];
    logic [31:0] ex_dat [8];
    logic        ex_err [8];

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack === 1'b1 || err === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: cyc=%0d ack=%0b err=%0b dat=%h, want no beat",
                             cyc_cnt, ack, err, rdat);
                end else begin
                    e = sb.pop_front();
                    if (ack !== !e.err || err !== e.err || rdat !== e.dat || cyc_cnt != e.cyc) begin
                        bad++;
                        $display("FAIL beat: got ack=%0b err=%0b dat=%h cyc=%0d, want ack=%0b err=%0b dat=%h cyc=%0d",
                                 ack, err, rdat, cyc_cnt, !e.err, e.err, e.dat, e.cyc);
                    end
                end
            end
        end
    end

    // beats: beats driven; n_exp: beats expected to complete; reset_at: beat after which reset hits
    task automatic xfer(input logic w, input logic [31:0] adr0, input int beats, input logic [3:0] s,
                        input int n_exp, input int reset_at);
        int   c0;
        int   n;
        logic got_err;
        @(posedge clk); #1;
        c0 = cyc_cnt;
        for (int k = 0; k < n_exp; k++) sb.push_back('{ex_err[k], ex_dat[k], c0 + 1 + WS + k});
        for (int k = 0; k < beats; k++) begin
            cyc = 1'b1; stb = 1'b1; wen = w; sel = s;
            adr  = adr0 + 32'(4 * k);
            wdat = tx_dat[k];
            cti  = (beats == 1) ? 3'b000 : ((k == beats - 1) ? 3'b111 : 3'b010);
            n = 0;
            while (ack !== 1'b1 && err !== 1'b1 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (ack !== 1'b1 && err !== 1'b1) begin
                total++; bad++;
                $display("FAIL timeout: beat %0d at %h got no ack/err, want a beat", k, adr);
                break;
            end
            got_err = err;
            if (k == reset_at) begin
                rst = 1'b1; cyc = 1'b0; stb = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
                rst = 1'b0;
                break;
            end
            @(posedge clk); #1;
            if (got_err) break;
        end
        cyc = 1'b0; stb = 1'b0; wen = 1'b0; cti = 3'b000;
    endtask

    task automatic single(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic e_err, input logic [31:0] e_dat);
        tx_dat[0] = d; ex_err[0] = e_err; ex_dat[0] = e_dat;
        xfer(w, a, 1, s, 1, -1);
    endtask

    initial begin : stim
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 3;
        if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", ack); end
        if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        if (rdat !== 32'h0) begin bad++; $display("FAIL reset_dat: got %h want 0", rdat); end
        @(posedge clk); #1;
        rst = 1'b0;

        single(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        single(1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF);
        single(1'b1, 32'h10, 32'h00AB0000, 4'b0100, 1'b0, 32'h0);
        single(1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 32'hDEABBEEF);

        for (int k = 0; k < 8; k++) begin
            tx_dat[k] = 32'hA500_0020 + 32'(4 * k);
            ex_err[k] = 1'b0;
            ex_dat[k] = 32'h0;
        end
        xfer(1'b1, 32'h20, 8, 4'hF, 8, -1);
        for (int k = 0; k < 8; k++) ex_dat[k] = 32'hA500_0020 + 32'(4 * k);
        xfer(1'b0, 32'h20, 8, 4'h0, 8, -1);

        single(1'b1, 32'h0, 32'h11223344, 4'hF, 1'b0, 32'h0);
        single(1'b0, TOP,   32'h0,        4'h0, 1'b1, 32'h0);
        single(1'b1, TOP,   32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
        single(1'b0, 32'h0, 32'h0,        4'h0, 1'b0, 32'h11223344);

        single(1'b1, TOP - 32'h8, 32'hCAFE00F8, 4'hF, 1'b0, 32'h0);
        single(1'b1, TOP - 32'h4, 32'hCAFE00FC, 4'hF, 1'b0, 32'h0);
        ex_err[0] = 1'b0; ex_dat[0] = 32'hCAFE00F8;
        ex_err[1] = 1'b0; ex_dat[1] = 32'hCAFE00FC;
        ex_err[2] = 1'b1; ex_dat[2] = 32'h0;
        xfer(1'b0, TOP - 32'h8, 4, 4'h0, 3, -1);

        // write request abandoned while the wait counter is running
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; wen = 1'b1; sel = 4'hF; adr = 32'h10; wdat = 32'h0BADF00D; cti = 3'b000;
        repeat (2) begin @(posedge clk); #1; end
        cyc = 1'b0; stb = 1'b0; wen = 1'b0;
        repeat (8) @(posedge clk);
        single(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEABBEEF);

        for (int k = 0; k < 8; k++) begin
            ex_err[k] = 1'b0;
            ex_dat[k] = 32'hA500_0020 + 32'(4 * k);
        end
        xfer(1'b0, 32'h20, 8, 4'h0, 2, 1);
        repeat (8) @(posedge clk);
        single(1'b0, 32'h24, 32'h0, 4'h0, 1'b0, 32'hA5000024);

        repeat (6) @(posedge clk);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d outstanding beats, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
